// File: rtl/alu_issue_stage.sv
// Decode/issue stage for ALU_Memory: a one-entry hold register decodes MIPS R-type ALU ops
// and issues them with operands from a shadow register file, stalling RAW hazards via a scoreboard.
module alu_issue_stage #(
    parameter int DATA_W      = 32,
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              Ewr,
    output logic [4:0]        Dir,
    output logic [2:0]        Sel,
    output logic [DATA_W-1:0] Op1,
    output logic [DATA_W-1:0] Op2,
    output logic [CNT_W-1:0]  pending,
    output logic              err_illegal
);

    logic [DATA_W-1:0] rf [32];
    logic [31:0]       sb;

    logic              vld_p0;
    logic [4:0]        rs_p0;
    logic [4:0]        rt_p0;
    logic [4:0]        rd_p0;
    logic [2:0]        sel_p0;

    logic              dec_legal;
    logic [2:0]        dec_sel;
    logic              is_nop;
    logic              accept;
    logic              wb_hit;
    logic              wb_clr;
    logic              hazard;
    logic              issue_now;
    logic              issue_wr;
    logic [DATA_W-1:0] op1_fwd;
    logic [DATA_W-1:0] op2_fwd;
    logic [31:0]       sb_nxt;
    logic [CNT_W-1:0]  pending_nxt;

    // Returns {legal, sel}; only op==0 with a supported funct is legal.
    function automatic logic [3:0] decode(input logic [5:0] op, input logic [5:0] funct);
        logic [3:0] r;
        r = 4'b0000;
        if (op == 6'd0) begin
            case (funct)
                6'h24:   r = {1'b1, 3'b000};
                6'h25:   r = {1'b1, 3'b001};
                6'h20:   r = {1'b1, 3'b010};
                6'h22:   r = {1'b1, 3'b110};
                6'h27:   r = {1'b1, 3'b100};
                6'h2A:   r = {1'b1, 3'b111};
                default: r = 4'b0000;
            endcase
        end
        return r;
    endfunction

    always_comb begin
        {dec_legal, dec_sel} = decode(in_instr[31:26], in_instr[5:0]);
        is_nop    = (in_instr == 32'd0);
        wb_hit    = wb_en && (wb_addr != 5'd0);
        wb_clr    = wb_hit && sb[wb_addr];
        // A same-cycle writeback to a source resolves its hazard through forwarding.
        hazard    = ((rs_p0 != 5'd0) && sb[rs_p0] && !(wb_en && (wb_addr == rs_p0))) ||
                    ((rt_p0 != 5'd0) && sb[rt_p0] && !(wb_en && (wb_addr == rt_p0))) ||
                    ((pending == CNT_W'(MAX_PENDING)) && (rd_p0 != 5'd0) && !wb_clr);
        issue_now = vld_p0 && !hazard;
        issue_wr  = issue_now && (rd_p0 != 5'd0);
        in_ready  = !vld_p0 || issue_now;
        accept    = in_valid && in_ready;
        op1_fwd   = (wb_hit && (wb_addr == rs_p0)) ? wb_data : rf[rs_p0];
        op2_fwd   = (wb_hit && (wb_addr == rt_p0)) ? wb_data : rf[rt_p0];
        // Issue is applied after writeback so a new issue to the same rd keeps its bit set.
        sb_nxt = sb;
        if (wb_clr) begin
            sb_nxt[wb_addr] = 1'b0;
        end
        if (issue_wr) begin
            sb_nxt[rd_p0] = 1'b1;
        end
        pending_nxt = pending + CNT_W'(issue_wr) - CNT_W'(wb_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
            sb          <= '0;
            pending     <= '0;
            vld_p0      <= 1'b0;
            rs_p0       <= '0;
            rt_p0       <= '0;
            rd_p0       <= '0;
            sel_p0      <= '0;
            Ewr         <= 1'b0;
            Dir         <= '0;
            Sel         <= '0;
            Op1         <= '0;
            Op2         <= '0;
            err_illegal <= 1'b0;
        end else begin
            if (wb_hit) begin
                rf[wb_addr] <= wb_data;
            end
            sb      <= sb_nxt;
            pending <= pending_nxt;

            // Accept boundary: NOPs and illegal words are consumed without entering the hold stage.
            if (accept) begin
                vld_p0 <= dec_legal;
                rs_p0  <= in_instr[25:21];
                rt_p0  <= in_instr[20:16];
                rd_p0  <= in_instr[15:11];
                sel_p0 <= dec_sel;
                if (!dec_legal && !is_nop) begin
                    err_illegal <= 1'b1;
                end
            end else if (issue_now) begin
                vld_p0 <= 1'b0;
            end

            // Issue boundary: registered outputs toward ALU_Memory.
            Ewr <= issue_wr;
            if (issue_now) begin
                Sel <= sel_p0;
                Dir <= rd_p0;
                Op1 <= op1_fwd;
                Op2 <= op2_fwd;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus randomized traffic
// compared against a transaction-level model built on an outstanding-destination queue.
module tb_alu_issue_stage;

    localparam int DATA_W      = 32;
    localparam int MAX_PENDING = 4;
    localparam int CNT_W       = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_instr = 32'd0;
    logic              wb_en = 1'b0;
    logic [4:0]        wb_addr = 5'd0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              Ewr;
    logic [4:0]        Dir;
    logic [2:0]        Sel;
    logic [DATA_W-1:0] Op1;
    logic [DATA_W-1:0] Op2;
    logic [CNT_W-1:0]  pending;
    logic              err_illegal;

    int checks = 0;
    int errors = 0;

    alu_issue_stage #(.DATA_W(DATA_W), .MAX_PENDING(MAX_PENDING), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .Ewr(Ewr), .Dir(Dir), .Sel(Sel),
        .Op1(Op1), .Op2(Op2), .pending(pending), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DATA_W-1:0] rf_m [32];
    int                outst[$];
    bit                m_hold_v;
    logic [4:0]        m_rs, m_rt, m_rd;
    logic [2:0]        m_sel;
    logic              e_ewr, e_err;
    logic [4:0]        e_dir;
    logic [2:0]        e_sel;
    logic [DATA_W-1:0] e_op1, e_op2;
    logic [5:0]        functs [6] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h27, 6'h2A};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        wb_en    = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input logic [5:0] f);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, f};
    endfunction

    function automatic bit in_outst(input int r);
        foreach (outst[i]) if (outst[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_decode(input logic [31:0] w, output bit legal, output logic [2:0] s);
        legal = 1'b1;
        s     = 3'd0;
        if (w[31:26] != 6'd0) legal = 1'b0;
        else case (w[5:0])
            6'h24: s = 3'b000;
            6'h25: s = 3'b001;
            6'h20: s = 3'b010;
            6'h22: s = 3'b110;
            6'h27: s = 3'b100;
            6'h2A: s = 3'b111;
            default: legal = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] gen_instr();
        int k;
        logic [4:0] rd;
        k = $urandom_range(0, 15);
        if (k == 0) return 32'd0;
        if (k == 1) return {6'($urandom_range(1, 63)), 26'($urandom)};
        do rd = 5'($urandom_range(0, 7));
        while (rd != 5'd0 && (in_outst(rd) || (m_hold_v && m_rd == rd)));
        return r_type($urandom_range(0, 7), $urandom_range(0, 7), rd, functs[$urandom_range(0, 5)]);
    endfunction

    function automatic void model_init();
        for (int i = 0; i < 32; i++) rf_m[i] = '0;
        outst.delete();
        m_hold_v = 1'b0;
        m_rs = '0; m_rt = '0; m_rd = '0; m_sel = '0;
        e_ewr = 1'b0; e_err = 1'b0; e_dir = '0; e_sel = '0; e_op1 = '0; e_op2 = '0;
    endfunction

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_step(output bit exp_ready);
        bit wclr, haz, issue, legal;
        logic [2:0] s;
        wclr = wb_en && wb_addr != 5'd0 && in_outst(wb_addr);
        haz = (m_rs != 0 && in_outst(m_rs) && !(wb_en && wb_addr == m_rs)) ||
              (m_rt != 0 && in_outst(m_rt) && !(wb_en && wb_addr == m_rt)) ||
              (outst.size() == MAX_PENDING && m_rd != 0 && !wclr);
        issue = m_hold_v && !haz;
        exp_ready = !m_hold_v || issue;
        e_ewr = issue && m_rd != 0;
        if (issue) begin
            e_op1 = (wb_en && wb_addr == m_rs && m_rs != 0) ? wb_data : rf_m[m_rs];
            e_op2 = (wb_en && wb_addr == m_rt && m_rt != 0) ? wb_data : rf_m[m_rt];
            e_sel = m_sel;
            e_dir = m_rd;
        end
        if (wb_en && wb_addr != 0) begin
            rf_m[wb_addr] = wb_data;
            foreach (outst[i]) if (outst[i] == wb_addr) begin outst.delete(i); break; end
        end
        if (issue && m_rd != 0) outst.push_back(m_rd);
        if (issue) m_hold_v = 1'b0;
        if (in_valid && exp_ready) begin
            model_decode(in_instr, legal, s);
            if (legal) begin
                m_hold_v = 1'b1;
                m_rs = in_instr[25:21]; m_rt = in_instr[20:16]; m_rd = in_instr[15:11]; m_sel = s;
            end else if (in_instr != 32'd0) e_err = 1'b1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (Ewr !== 1'b0) begin errors++; $display("FAIL reset_ewr: got %b expected 0", Ewr); end
        checks++; if (Dir !== 5'd0) begin errors++; $display("FAIL reset_dir: got %0d expected 0", Dir); end
        checks++; if (Sel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", Sel); end
        checks++; if (Op1 !== '0 || Op2 !== '0) begin errors++; $display("FAIL reset_ops: got %0d/%0d expected 0/0", Op1, Op2); end
        checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending: got %0d expected 0", pending); end
        checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_illegal); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_add();
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 1050; tick();
        wb_addr = 5'd2; wb_data = 1150; tick();
        wb_en = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00221820; tick();
        in_valid = 1'b0;
        checks++; if (Ewr !== 1'b0) begin errors++; $display("FAIL add_early_ewr: got %b expected 0", Ewr); end
        tick();
        checks++; if (Ewr !== 1'b1) begin errors++; $display("FAIL add_ewr: got %b expected 1", Ewr); end
        checks++; if (Sel !== 3'b010) begin errors++; $display("FAIL add_sel: got %b expected 010", Sel); end
        checks++; if (Op1 !== 1050 || Op2 !== 1150) begin errors++; $display("FAIL add_ops: got %0d/%0d expected 1050/1150", Op1, Op2); end
        checks++; if (Dir !== 5'd3) begin errors++; $display("FAIL add_dir: got %0d expected 3", Dir); end
        checks++; if (pending !== 3'd1) begin errors++; $display("FAIL add_pending: got %0d expected 1", pending); end
        tick();
        checks++; if (Ewr !== 1'b0) begin errors++; $display("FAIL add_ewr_drop: got %b expected 0", Ewr); end
    endtask

    task automatic test_raw_stall();
        in_valid = 1'b1; in_instr = 32'h00612022; tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_ready: got %b expected 0", in_ready); end
        tick();
        checks++; if (Ewr !== 1'b0) begin errors++; $display("FAIL raw_stall_ewr: got %b expected 0", Ewr); end
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 2200; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_wb_ready: got %b expected 1", in_ready); end
        tick();
        wb_en = 1'b0;
        checks++; if (Ewr !== 1'b1) begin errors++; $display("FAIL raw_ewr: got %b expected 1", Ewr); end
        checks++; if (Op1 !== 2200 || Op2 !== 1050) begin errors++; $display("FAIL raw_fwd_ops: got %0d/%0d expected 2200/1050", Op1, Op2); end
        checks++; if (Sel !== 3'b110 || Dir !== 5'd4) begin errors++; $display("FAIL raw_sel_dir: got %b/%0d expected 110/4", Sel, Dir); end
        checks++; if (pending !== 3'd1) begin errors++; $display("FAIL raw_pending: got %0d expected 1", pending); end
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 500; tick();
        wb_en = 1'b0;
        checks++; if (pending !== 3'd0 || Ewr !== 1'b0) begin errors++; $display("FAIL raw_drain: got pending %0d ewr %b expected 0 0", pending, Ewr); end
    endtask

    task automatic test_max_pending();
        int idx = 0;
        int ewr_cnt = 0;
        bit fire;
        for (int cyc = 0; cyc < 14; cyc++) begin
            in_valid = (idx < 6);
            in_instr = r_type(1, 2, 5 + idx, 6'h25);
            #1;
            fire = in_valid && in_ready;
            tick();
            if (Ewr) ewr_cnt++;
            if (fire) idx++;
        end
        checks++; if (ewr_cnt != 4) begin errors++; $display("FAIL maxp_pulses: got %0d expected 4", ewr_cnt); end
        checks++; if (pending !== 3'd4) begin errors++; $display("FAIL maxp_pending: got %0d expected 4", pending); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL maxp_ready: got %b expected 0", in_ready); end
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 77; tick();
        wb_en = 1'b0; in_valid = 1'b0;
        checks++; if (Ewr !== 1'b1 || Dir !== 5'd9) begin errors++; $display("FAIL maxp_fifth: got ewr %b dir %0d expected 1 9", Ewr, Dir); end
        checks++; if (Op1 !== 1050 || Op2 !== 1150) begin errors++; $display("FAIL maxp_ops: got %0d/%0d expected 1050/1150", Op1, Op2); end
        checks++; if (pending !== 3'd4) begin errors++; $display("FAIL maxp_pending2: got %0d expected 4", pending); end
        tick();
        checks++; if (Ewr !== 1'b0) begin errors++; $display("FAIL maxp_stall_again: got %b expected 0", Ewr); end
    endtask

    task automatic test_reset_mid_stall();
        rst_n = 1'b0; #1;
        checks++; if (Ewr !== 1'b0 || Dir !== 5'd0 || Sel !== 3'd0) begin errors++; $display("FAIL rst_async_ctl: got ewr %b dir %0d sel %0d expected 0", Ewr, Dir, Sel); end
        checks++; if (Op1 !== '0 || Op2 !== '0) begin errors++; $display("FAIL rst_async_ops: got %0d/%0d expected 0/0", Op1, Op2); end
        checks++; if (pending !== '0 || err_illegal !== 1'b0) begin errors++; $display("FAIL rst_async_pend: got %0d err %b expected 0 0", pending, err_illegal); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (Ewr !== 1'b0) begin errors++; $display("FAIL rst_discard cyc %0d: got ewr %b expected 0", i, Ewr); end
        end
        in_valid = 1'b1; in_instr = 32'h00221820; tick();
        in_valid = 1'b0; tick();
        checks++; if (Ewr !== 1'b1 || Op1 !== '0 || Op2 !== '0) begin errors++; $display("FAIL rst_rf_clear: got ewr %b ops %0d/%0d expected 1 0/0", Ewr, Op1, Op2); end
        do_reset();
    endtask

    task automatic test_nop_illegal();
        in_valid = 1'b1; in_instr = 32'h00221820; tick();
        in_valid = 1'b0; tick(); tick();
        in_valid = 1'b1; in_instr = 32'h00000000; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nop_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (Ewr !== 1'b0 || pending !== 3'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL nop_effect cyc %0d: got ewr %b pend %0d rdy %b expected 0 1 1", i, Ewr, pending, in_ready); end
            tick();
        end
        checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL nop_err: got %b expected 0", err_illegal); end
        in_valid = 1'b1; in_instr = 32'hFC000000; tick();
        in_valid = 1'b0;
        checks++; if (err_illegal !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b expected 1", err_illegal); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (Ewr !== 1'b0 || err_illegal !== 1'b1) begin errors++; $display("FAIL illegal_sticky cyc %0d: got ewr %b err %b expected 0 1", i, Ewr, err_illegal); end
        end
    endtask

    task automatic test_rd_zero();
        in_valid = 1'b1; in_instr = 32'h0022002A; tick();
        in_valid = 1'b0; tick();
        checks++; if (Ewr !== 1'b0) begin errors++; $display("FAIL rd0_ewr: got %b expected 0", Ewr); end
        checks++; if (Sel !== 3'b111 || Dir !== 5'd0) begin errors++; $display("FAIL rd0_sel_dir: got %b/%0d expected 111/0", Sel, Dir); end
        checks++; if (pending !== 3'd1) begin errors++; $display("FAIL rd0_pending: got %0d expected 1", pending); end
        checks++; if (err_illegal !== 1'b1) begin errors++; $display("FAIL rd0_err_sticky: got %b expected 1", err_illegal); end
        do_reset();
    endtask

    task automatic test_random();
        bit er;
        bit last_acc = 1'b1;
        model_init();
        for (int cyc = 0; cyc < 400; cyc++) begin
            checks++; if (Ewr !== e_ewr) begin errors++; $display("FAIL rnd_ewr cyc %0d: got %b expected %b", cyc, Ewr, e_ewr); end
            checks++; if (Dir !== e_dir || Sel !== e_sel) begin errors++; $display("FAIL rnd_dir_sel cyc %0d: got %0d/%0d expected %0d/%0d", cyc, Dir, Sel, e_dir, e_sel); end
            checks++; if (Op1 !== e_op1 || Op2 !== e_op2) begin errors++; $display("FAIL rnd_ops cyc %0d: got %h/%h expected %h/%h", cyc, Op1, Op2, e_op1, e_op2); end
            checks++; if (pending !== CNT_W'(outst.size())) begin errors++; $display("FAIL rnd_pending cyc %0d: got %0d expected %0d", cyc, pending, outst.size()); end
            checks++; if (err_illegal !== e_err) begin errors++; $display("FAIL rnd_err cyc %0d: got %b expected %b", cyc, err_illegal, e_err); end
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_instr = gen_instr();
            end
            wb_en = ($urandom_range(0, 9) < 4);
            if (outst.size() > 0 && $urandom_range(0, 3) != 0) wb_addr = 5'(outst[$urandom_range(0, outst.size() - 1)]);
            else wb_addr = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            #1;
            model_step(er);
            checks++; if (in_ready !== er) begin errors++; $display("FAIL rnd_ready cyc %0d: got %b expected %b", cyc, in_ready, er); end
            last_acc = in_valid && er;
            tick();
        end
        in_valid = 1'b0;
        wb_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_raw_stall();
        test_max_pending();
        test_reset_mid_stall();
        test_nop_illegal();
        test_rd_zero();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
